// File: rtl/serdesphy_tx_serializer.sv
// Parallel-to-serial TX serializer with data / idle / PRBS7 word sources.
// Optional feature macro: SERDESPHY_TX_PRBS_EN enables the PRBS7 generator
// (mode 2'b10). Without it no LFSR exists and mode 2'b10 sends IDLE_WORD.
// Shift register holds the word with the first bit to send at the MSB.
// The underrun pulse is registered and coincides with the first bit of the
// substituted idle word.
module serdesphy_tx_serializer #(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       LSB_FIRST = 0,
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'({9{2'b10}} >> (18 - DATA_W))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txp,
  output logic              txn,
  output logic              word_start,
  output logic              underrun
);

  localparam int unsigned       CNT_W     = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DATA_W - 1);
  localparam logic [1:0]        MODE_DATA = 2'b00;

  typedef enum logic {ST_OFF = 1'b0, ST_RUN = 1'b1} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_sh;
  logic                r_txp;
  logic                r_txn;
  logic                r_word_start;
  logic                r_underrun;

  logic                w_boundary;
  logic [DATA_W-1:0]   w_load;
  logic                w_underrun;

  // Put the first bit to transmit at the MSB according to LSB_FIRST
  function automatic logic [DATA_W-1:0] f_order(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] y;
    y = x;
    if (LSB_FIRST != 0) begin
      for (int i = 0; i < int'(DATA_W); i++) y[i] = x[DATA_W-1-i];
    end
    return y;
  endfunction

`ifdef SERDESPHY_TX_PRBS_EN
  localparam logic [1:0] MODE_PRBS = 2'b10;
  localparam logic [6:0] PRBS_SEED = 7'h7F;

  logic [6:0]          r_lfsr;
  logic [6:0]          w_lfsr_next;
  logic [DATA_W-1:0]   w_prbs_word;

  // Unroll DATA_W LFSR steps; first generated bit lands at the MSB
  always_comb begin
    w_lfsr_next = r_lfsr;
    w_prbs_word = '0;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      w_prbs_word[i] = w_lfsr_next[6];
      w_lfsr_next    = {w_lfsr_next[5:0], w_lfsr_next[6] ^ w_lfsr_next[5]};
    end
  end

  // LFSR sits at seed while off, advances one word per PRBS boundary
  always_ff @(posedge clk) begin
    if (rst || !tx_en) begin
      r_lfsr <= PRBS_SEED;
    end else if (w_boundary && (mode == MODE_PRBS)) begin
      r_lfsr <= w_lfsr_next;
    end
  end
`endif

  assign w_boundary = tx_en & (r_cnt == CNT_MAX);
  assign tx_ready   = ~rst & w_boundary & (mode == MODE_DATA);

  // Select the word to load at the next boundary
  always_comb begin
    w_load     = f_order(IDLE_WORD);
    w_underrun = 1'b0;
    case (mode)
      MODE_DATA: begin
        if (tx_valid) w_load = f_order(tx_data);
        else          w_underrun = 1'b1;
      end
`ifdef SERDESPHY_TX_PRBS_EN
      MODE_PRBS: w_load = w_prbs_word;
`endif
      default: ;
    endcase
  end

  // OFF/RUN FSM with bit counter, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (rst || !tx_en) begin
      r_state      <= ST_OFF;
      r_cnt        <= CNT_MAX;
      r_sh         <= '0;
      r_txp        <= 1'b0;
      r_txn        <= 1'b0;
      r_word_start <= 1'b0;
      r_underrun   <= 1'b0;
    end else if (w_boundary) begin
      r_state      <= ST_RUN;
      r_cnt        <= '0;
      r_txp        <= w_load[DATA_W-1];
      r_txn        <= ~w_load[DATA_W-1];
      r_sh         <= w_load << 1;
      r_word_start <= 1'b1;
      r_underrun   <= w_underrun;
    end else if (r_state == ST_RUN) begin
      r_cnt        <= r_cnt + CNT_W'(1);
      r_txp        <= r_sh[DATA_W-1];
      r_txn        <= ~r_sh[DATA_W-1];
      r_sh         <= r_sh << 1;
      r_word_start <= 1'b0;
      r_underrun   <= 1'b0;
    end
  end

  assign txp        = r_txp;
  assign txn        = r_txn;
  assign word_start = r_word_start;
  assign underrun   = r_underrun;

endmodule

// File: tb/tb_serdesphy_tx_serializer.sv
// Directed bench for serdesphy_tx_serializer at DATA_W=8, MSB first.
// Honors SERDESPHY_TX_PRBS_EN for the PRBS expectations.
module tb_serdesphy_tx_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic [1:0] mode;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txp;
  logic       txn;
  logic       word_start;
  logic       underrun;

  int n_checks = 0;
  int n_fail   = 0;

  serdesphy_tx_serializer #(.DATA_W(8)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .mode       (mode),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .txp        (txp),
    .txn        (txn),
    .word_start (word_start),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Check one 8-bit word on the line; mode switches to mid_mode at bit 3,
  // next-boundary inputs are applied during bit 7.
  task automatic word(input string tag, input logic [7:0] exp_w, input logic exp_ur,
                      input logic n_en, input logic [1:0] n_mode, input logic n_valid,
                      input logic [7:0] n_data, input logic exp_rdy, input logic [1:0] mid_mode);
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      if (b == 3) mode = mid_mode;
      if (b == 7) begin
        tx_en = n_en; mode = n_mode; tx_valid = n_valid; tx_data = n_data;
      end
      #1;
      chk($sformatf("%s_b%0d_txp", tag, b), 32'(txp), 32'(exp_w[7-b]));
      chk($sformatf("%s_b%0d_txn", tag, b), 32'(txn), 32'(!exp_w[7-b]));
      chk($sformatf("%s_b%0d_ws", tag, b), 32'(word_start), 32'(b == 0));
      chk($sformatf("%s_b%0d_ur", tag, b), 32'(underrun), 32'((b == 0) ? exp_ur : 1'b0));
      chk($sformatf("%s_b%0d_rdy", tag, b), 32'(tx_ready), 32'((b == 7) ? exp_rdy : 1'b0));
    end
  endtask

  logic [7:0] w96;
  logic [7:0] wc3;
`ifdef SERDESPHY_TX_PRBS_EN
  logic [255:0] bits;
  int ones;
  int per_err;
  int ws_err;
  logic [7:0] first8;
`endif

  initial begin
    rst = 1'b1; tx_en = 1'b0; mode = 2'b00; tx_data = 8'h00; tx_valid = 1'b0;
    w96 = 8'h96;
    wc3 = 8'hC3;
    repeat (3) @(negedge clk);
    // Reset held with active inputs: everything quiet, tx_ready blocked
    tx_en = 1'b1; tx_valid = 1'b1; tx_data = 8'hA5;
    #1;
    chk("rst_rdy", 32'(tx_ready), 32'd0);
    chk("rst_txp", 32'(txp), 32'd0);
    chk("rst_txn", 32'(txn), 32'd0);
    chk("rst_ws",  32'(word_start), 32'd0);
    chk("rst_ur",  32'(underrun), 32'd0);
    // Cycle 0: first boundary
    @(negedge clk); rst = 1'b0; #1;
    chk("c0_rdy", 32'(tx_ready), 32'd1);
    chk("c0_txp", 32'(txp), 32'd0);

    word("a5",   8'hA5, 1'b0, 1'b1, 2'b00, 1'b1, 8'hFF, 1'b1, 2'b00);
    word("ff",   8'hFF, 1'b0, 1'b1, 2'b00, 1'b1, 8'h00, 1'b1, 2'b00);
    word("00",   8'h00, 1'b0, 1'b1, 2'b00, 1'b0, 8'h00, 1'b1, 2'b00);
    word("ur",   8'hAA, 1'b1, 1'b1, 2'b01, 1'b1, 8'h3C, 1'b0, 2'b00);
    word("idle", 8'hAA, 1'b0, 1'b1, 2'b00, 1'b1, 8'h3C, 1'b1, 2'b01);
    word("3c",   8'h3C, 1'b0, 1'b1, 2'b00, 1'b1, 8'h5A, 1'b1, 2'b11);
    word("5a",   8'h5A, 1'b0, 1'b1, 2'b11, 1'b1, 8'h00, 1'b0, 2'b00);
    word("rsv",  8'hAA, 1'b0, 1'b1, 2'b00, 1'b1, 8'hC3, 1'b1, 2'b11);

    // Abort C3 during bit 3
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      if (b == 3) tx_en = 1'b0;
      #1;
      chk($sformatf("abort_b%0d_txp", b), 32'(txp), 32'(wc3[7-b]));
    end
    chk("abort_rdy", 32'(tx_ready), 32'd0);
    @(negedge clk); #1;
    chk("off_txp", 32'(txp), 32'd0);
    chk("off_txn", 32'(txn), 32'd0);
    chk("off_ws",  32'(word_start), 32'd0);
    chk("off_ur",  32'(underrun), 32'd0);
    chk("off_rdy", 32'(tx_ready), 32'd0);
    // Re-enable straight into PRBS mode from OFF
    @(negedge clk); tx_en = 1'b1; mode = 2'b10; tx_valid = 1'b0; #1;
    chk("prbs_c0_rdy", 32'(tx_ready), 32'd0);
    chk("prbs_c0_txp", 32'(txp), 32'd0);

`ifdef SERDESPHY_TX_PRBS_EN
    ws_err = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (c == 255) begin mode = 2'b00; tx_valid = 1'b1; tx_data = 8'h96; end
      #1;
      bits[c] = txp;
      if (word_start !== ((c % 8) == 0) || txn !== !txp) ws_err++;
      if (c == 255) chk("prbs_end_rdy", 32'(tx_ready), 32'd1);
    end
    for (int i = 0; i < 8; i++) first8[7-i] = bits[i];
    chk("prbs_first", 32'(first8), 32'hFE);
    ones = 0;
    for (int i = 0; i < 127; i++) ones += int'(bits[i]);
    chk("prbs_ones", 32'(ones), 32'd64);
    per_err = 0;
    for (int i = 0; i < 129; i++) if (bits[i] !== bits[i+127]) per_err++;
    chk("prbs_period", 32'(per_err), 32'd0);
    chk("prbs_ws_txn", 32'(ws_err), 32'd0);
`else
    word("prbs0", 8'hAA, 1'b0, 1'b1, 2'b10, 1'b0, 8'h00, 1'b0, 2'b10);
    word("prbs1", 8'hAA, 1'b0, 1'b1, 2'b00, 1'b1, 8'h96, 1'b1, 2'b10);
`endif

    // Reset during bit 5 of 96
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      if (b == 5) rst = 1'b1;
      #1;
      chk($sformatf("r96_b%0d_txp", b), 32'(txp), 32'(w96[7-b]));
    end
    tx_data = 8'hA5;
    @(negedge clk); #1;
    chk("rst2_txp", 32'(txp), 32'd0);
    chk("rst2_txn", 32'(txn), 32'd0);
    chk("rst2_ws",  32'(word_start), 32'd0);
    chk("rst2_ur",  32'(underrun), 32'd0);
    chk("rst2_rdy", 32'(tx_ready), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst2_c0_rdy", 32'(tx_ready), 32'd1);
    word("rst_a5", 8'hA5, 1'b0, 1'b0, 2'b00, 1'b1, 8'h00, 1'b0, 2'b00);
    @(negedge clk); #1;
    chk("end_txp", 32'(txp), 32'd0);
    chk("end_txn", 32'(txn), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
